// File: rtl/wb_stage_pkg.sv
// Shared widths, load encodings, stall bit indices and the MEM/WB bus layout for the write-back stage.
package wb_stage_pkg;

  localparam int MEM_TO_WB_WD = 73;
  localparam int WB_TO_RF_WD  = 38;
  localparam int STALL_WD     = 6;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'b000,
    LOAD_LB   = 3'b001,
    LOAD_LBU  = 3'b010,
    LOAD_LH   = 3'b011,
    LOAD_LHU  = 3'b100,
    LOAD_LW   = 3'b101
  } load_op_e;

  // Field order matches the packed mem_to_wb_bus, MSB first.
  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [2:0]  load_op;
  } mem_to_wb_t;

  function automatic logic load_op_valid(input logic [2:0] op);
    return (op != 3'b000) && (op <= 3'b101);
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load-data alignment: byte/half selection with sign or zero extension.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]  load_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_ld
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // addr[0] is ignored for halfwords; misaligned accesses never reach WB.
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    wdata_ld = rdata;
    case (load_op)
      LOAD_LB:  wdata_ld = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: wdata_ld = {24'h0, byte_sel};
      LOAD_LH:  wdata_ld = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: wdata_ld = {16'h0, half_sel};
      default:  wdata_ld = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB register, SRAM read-data hold across stalls, regfile/forwarding write port.
// Define WB_DEBUG_TRACE_EN to drive the debug_* trace outputs; otherwise they are tied to 0.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [WB_TO_RF_WD-1:0]  wb_to_rf_bus,
  output logic [WB_TO_RF_WD-1:0]  wb_to_id_bus,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);

  mem_to_wb_t  r_bus_q, r_bus_d;
  logic        held_v_q, held_v_d;
  logic [31:0] held_data_q, held_data_d;

  logic        advance;
  logic [31:0] rdata_eff;
  logic [31:0] wdata_ld;
  logic [31:0] wdata;
  logic        we;
  logic        unused_stall;

  assign advance = ~stall[STALL_MEM] | ~stall[STALL_WB];
  assign unused_stall = ^stall[STALL_EX:STALL_PC];

  // Advancing the register always discards held data, even if WB is also stalled.
  always_comb begin
    r_bus_d     = r_bus_q;
    held_v_d    = held_v_q;
    held_data_d = held_data_q;
    if (!stall[STALL_MEM]) begin
      r_bus_d = mem_to_wb_t'(mem_to_wb_bus);
    end else if (!stall[STALL_WB]) begin
      r_bus_d = '0;
    end
    if (advance) begin
      held_v_d = 1'b0;
    end else if (stall[STALL_WB] && !held_v_q) begin
      held_v_d    = 1'b1;
      held_data_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_q     <= '0;
      held_v_q    <= 1'b0;
      held_data_q <= '0;
    end else begin
      r_bus_q     <= r_bus_d;
      held_v_q    <= held_v_d;
      held_data_q <= held_data_d;
    end
  end

  assign rdata_eff = held_v_q ? held_data_q : data_sram_rdata;

  load_align u_load_align (
    .load_op  (r_bus_q.load_op),
    .addr     (r_bus_q.ex_result[1:0]),
    .rdata    (rdata_eff),
    .wdata_ld (wdata_ld)
  );

  assign wdata = load_op_valid(r_bus_q.load_op) ? wdata_ld : r_bus_q.ex_result;
  assign we    = r_bus_q.rf_we & ~stall[STALL_WB];

  assign wb_to_rf_bus = {we, r_bus_q.rf_waddr, wdata};
  assign wb_to_id_bus = {we, r_bus_q.rf_waddr, wdata};

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = r_bus_q.pc;
  assign debug_wb_rf_wen   = {4{we}};
  assign debug_wb_rf_wnum  = r_bus_q.rf_waddr;
  assign debug_wb_rf_wdata = wdata;
`else
  logic unused_pc;
  assign unused_pc         = ^r_bus_q.pc;
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_wen   = '0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table of single-instruction vectors plus stall, bubble and reset sequences.
// Debug expectations follow WB_DEBUG_TRACE_EN, matching the build of the design.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [72:0] mem_to_wb_bus;
  logic [31:0] data_sram_rdata;
  logic [37:0] wb_to_rf_bus;
  logic [37:0] wb_to_id_bus;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [72:0] bus;
    logic [31:0] rdata;
    logic [37:0] expRf;
  } vec_t;

  vec_t vecs[14];

  wb_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .data_sram_rdata   (data_sram_rdata),
    .wb_to_rf_bus      (wb_to_rf_bus),
    .wb_to_id_bus      (wb_to_id_bus),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [72:0] mkBus(input logic [31:0] pc, input logic we,
                                        input logic [4:0] waddr, input logic [31:0] ex,
                                        input logic [2:0] op);
    return {pc, we, waddr, ex, op};
  endfunction

  function automatic logic [37:0] mkRf(input logic we, input logic [4:0] waddr,
                                       input logic [31:0] wdata);
    return {we, waddr, wdata};
  endfunction

  task automatic applyStimulus(input logic [72:0] bus, input logic [5:0] st,
                               input logic [31:0] rd);
    mem_to_wb_bus   = bus;
    stall           = st;
    data_sram_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [37:0] expRf,
                             input logic [31:0] expPc);
    logic [72:0] expDbg;
    logic [72:0] actDbg;
`ifdef WB_DEBUG_TRACE_EN
    expDbg = {expPc, {4{expRf[37]}}, expRf[36:32], expRf[31:0]};
`else
    expDbg = '0;
`endif
    actDbg = {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata};
    checks++;
    if (wb_to_rf_bus !== expRf) begin
      errors++;
      $display("[TB] FAIL %s rf actual=%h required=%h", name, wb_to_rf_bus, expRf);
    end
    checks++;
    if (wb_to_id_bus !== expRf) begin
      errors++;
      $display("[TB] FAIL %s id actual=%h required=%h", name, wb_to_id_bus, expRf);
    end
    checks++;
    if (actDbg !== expDbg) begin
      errors++;
      $display("[TB] FAIL %s debug actual=%h required=%h", name, actDbg, expDbg);
    end
  endtask

  initial begin
    logic [31:0] r;
    r = 32'h80FF7F01;
    vecs[0]  = '{mkBus(32'hBFC00000, 1'b1, 5'd8, 32'h12345678, LOAD_NONE), 32'h0, mkRf(1'b1, 5'd8, 32'h12345678)};
    vecs[1]  = '{mkBus(32'hBFC00004, 1'b1, 5'd9, 32'h00001003, LOAD_LB),  r, mkRf(1'b1, 5'd9, 32'hFFFFFF80)};
    vecs[2]  = '{mkBus(32'hBFC00008, 1'b1, 5'd9, 32'h00001003, LOAD_LBU), r, mkRf(1'b1, 5'd9, 32'h00000080)};
    vecs[3]  = '{mkBus(32'hBFC0000C, 1'b1, 5'd9, 32'h00001002, LOAD_LH),  r, mkRf(1'b1, 5'd9, 32'hFFFF80FF)};
    vecs[4]  = '{mkBus(32'hBFC00010, 1'b1, 5'd9, 32'h00001000, LOAD_LHU), r, mkRf(1'b1, 5'd9, 32'h00007F01)};
    vecs[5]  = '{mkBus(32'hBFC00014, 1'b1, 5'd4, 32'h00001001, LOAD_LB),  r, mkRf(1'b1, 5'd4, 32'h0000007F)};
    vecs[6]  = '{mkBus(32'hBFC00018, 1'b1, 5'd4, 32'h00001002, LOAD_LBU), r, mkRf(1'b1, 5'd4, 32'h000000FF)};
    vecs[7]  = '{mkBus(32'hBFC0001C, 1'b1, 5'd4, 32'h00001000, LOAD_LB),  r, mkRf(1'b1, 5'd4, 32'h00000001)};
    vecs[8]  = '{mkBus(32'hBFC00020, 1'b1, 5'd5, 32'h00001003, LOAD_LH),  r, mkRf(1'b1, 5'd5, 32'hFFFF80FF)};
    vecs[9]  = '{mkBus(32'hBFC00024, 1'b1, 5'd6, 32'h00001000, LOAD_LW),  r, mkRf(1'b1, 5'd6, 32'h80FF7F01)};
    vecs[10] = '{mkBus(32'hBFC00028, 1'b1, 5'd3, 32'hA5A5A5A5, 3'b110),   r, mkRf(1'b1, 5'd3, 32'hA5A5A5A5)};
    vecs[11] = '{mkBus(32'hBFC0002C, 1'b1, 5'd0, 32'h0000BEEF, LOAD_NONE), r, mkRf(1'b1, 5'd0, 32'h0000BEEF)};
    vecs[12] = '{mkBus(32'hBFC00030, 1'b0, 5'd7, 32'h00000042, LOAD_LW),  r, mkRf(1'b0, 5'd7, 32'h80FF7F01)};
    vecs[13] = '{mkBus(32'hBFC00034, 1'b1, 5'd2, 32'h5A5A5A5A, 3'b111),   r, mkRf(1'b1, 5'd2, 32'h5A5A5A5A)};

    rst = 1'b1;
    applyStimulus('0, 6'h00, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset", '0, 32'h0);
    rst = 1'b0;

    // Each vector enters WB at one edge; its read data is presented during that cycle.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].bus, 6'h00, 32'h0);
      tick();
      data_sram_rdata = vecs[i].rdata;
      mem_to_wb_bus   = '0;
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].expRf, vecs[i].bus[72:41]);
    end

    // Bubble: MEM stalled, WB free.
    applyStimulus(mkBus(32'hBFC00100, 1'b1, 5'd5, 32'hAAAA0005, LOAD_NONE), 6'h00, 32'h0);
    tick();
    #1;
    checkOutput("pre_bubble", mkRf(1'b1, 5'd5, 32'hAAAA0005), 32'hBFC00100);
    applyStimulus(mkBus(32'hBFC00104, 1'b1, 5'd6, 32'hBBBB0006, LOAD_NONE), 6'b010000, 32'h0);
    tick();
    #1;
    checkOutput("bubble", '0, 32'h0);

    // Load held in WB for three stalled cycles; only the first cycle's data is valid.
    applyStimulus(mkBus(32'hBFC00200, 1'b1, 5'd10, 32'h00000100, LOAD_LW), 6'h00, 32'h0);
    tick();
    applyStimulus('0, 6'h3F, 32'hDEADBEEF);
    #1;
    checkOutput("stall_c1", mkRf(1'b0, 5'd10, 32'hDEADBEEF), 32'hBFC00200);
    tick();
    data_sram_rdata = 32'h0BADF00D;
    #1;
    checkOutput("stall_c2", mkRf(1'b0, 5'd10, 32'hDEADBEEF), 32'hBFC00200);
    tick();
    data_sram_rdata = 32'h55555555;
    #1;
    checkOutput("stall_c3", mkRf(1'b0, 5'd10, 32'hDEADBEEF), 32'hBFC00200);
    tick();
    applyStimulus(mkBus(32'hBFC00204, 1'b1, 5'd11, 32'h00000200, LOAD_LW), 6'h00, 32'h77777777);
    #1;
    checkOutput("release", mkRf(1'b1, 5'd10, 32'hDEADBEEF), 32'hBFC00200);
    tick();
    applyStimulus('0, 6'h00, 32'h13579BDF);
    #1;
    checkOutput("fresh_after_release", mkRf(1'b1, 5'd11, 32'h13579BDF), 32'hBFC00204);

    // Reset arriving while a load is held must discard the held word.
    applyStimulus(mkBus(32'hBFC00300, 1'b1, 5'd12, 32'h00000300, LOAD_LW), 6'h00, 32'h0);
    tick();
    applyStimulus('0, 6'h3F, 32'hCAFEF00D);
    tick();
    data_sram_rdata = 32'h99999999;
    rst = 1'b1;
    tick();
    #1;
    checkOutput("reset_mid_stall", '0, 32'h0);
    rst = 1'b0;
    applyStimulus(mkBus(32'hBFC00400, 1'b1, 5'd13, 32'h00000400, LOAD_LW), 6'h00, 32'h0);
    #1;
    checkOutput("first_after_reset", '0, 32'h0);
    tick();
    applyStimulus('0, 6'h00, 32'h2468ACE0);
    #1;
    checkOutput("load_after_reset", mkRf(1'b1, 5'd13, 32'h2468ACE0), 32'hBFC00400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
